// File: rtl/control_unit.sv
// LC-3 microsequencer: fetch/decode/execute control for ADD, AND, NOT, LD, ST, BR, LEA, JMP.
// Moore-decoded controls from a 6-bit state using LC-3 numbering. Only o_Illegal and the BR branch depend on inputs.
//
//   state | meaning
//   ------+------------------------------------------------
//     18  | FETCH1   MAR<-PC, PC<-PC+1
//     33  | FETCH2   MDR<-M[MAR], wait on i_R
//     35  | FETCH3   IR<-MDR
//     32  | DECODE   dispatch on IR[15:12]
//   1/5/9 | ADD/AND/NOT  DR<-ALU, set CC
//     14  | LEA      DR<-PC+off9
//      2  | LD1      MAR<-PC+off9
//     25  | LD2      MDR<-M[MAR], wait on i_R
//     27  | LD3      DR<-MDR, set CC
//      3  | ST1      MAR<-PC+off9
//     23  | ST2      MDR<-SR
//     16  | ST3      M[MAR]<-MDR, wait on i_R
//      0  | BR       test condition codes
//     22  | BR taken PC<-PC+off9
//     12  | JMP      PC<-BaseR
module control_unit (
  input  logic        i_CLK,
  input  logic        i_Reset,
  input  logic [15:0] i_IR,
  input  logic        i_N,
  input  logic        i_Z,
  input  logic        i_P,
  input  logic        i_R,
  output logic        o_LD_MAR,
  output logic        o_LD_MDR,
  output logic        o_LD_IR,
  output logic        o_LD_REG,
  output logic        o_LD_CC,
  output logic        o_LD_PC,
  output logic        o_GatePC,
  output logic        o_GateMDR,
  output logic        o_GateALU,
  output logic        o_GateMARMUX,
  output logic [1:0]  o_ALUK,
  output logic [1:0]  o_SR1MUX,
  output logic [1:0]  o_DRMUX,
  output logic [1:0]  o_PCMUX,
  output logic        o_ADDR1MUX,
  output logic [1:0]  o_ADDR2MUX,
  output logic        o_MARMUX,
  output logic        o_MIO_EN,
  output logic        o_R_W,
  output logic        o_Illegal,
  output logic [5:0]  o_State
);

  typedef enum logic [5:0] {
    S_BR      = 6'd0,
    S_ADD     = 6'd1,
    S_LD1     = 6'd2,
    S_ST1     = 6'd3,
    S_AND     = 6'd5,
    S_NOT     = 6'd9,
    S_JMP     = 6'd12,
    S_LEA     = 6'd14,
    S_ST3     = 6'd16,
    S_FETCH1  = 6'd18,
    S_BR_TAKE = 6'd22,
    S_ST2     = 6'd23,
    S_LD2     = 6'd25,
    S_LD3     = 6'd27,
    S_DECODE  = 6'd32,
    S_FETCH2  = 6'd33,
    S_FETCH3  = 6'd35
  } state_t;

  state_t state, state_nxt;
  logic   br_taken;
  logic   unused_ir;

  assign unused_ir = ^i_IR[8:0];
  assign br_taken  = (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P);
  assign o_State   = state;

  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) state <= S_FETCH1;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = S_FETCH1;
    o_LD_MAR     = 1'b0;
    o_LD_MDR     = 1'b0;
    o_LD_IR      = 1'b0;
    o_LD_REG     = 1'b0;
    o_LD_CC      = 1'b0;
    o_LD_PC      = 1'b0;
    o_GatePC     = 1'b0;
    o_GateMDR    = 1'b0;
    o_GateALU    = 1'b0;
    o_GateMARMUX = 1'b0;
    o_ALUK       = 2'b00;
    o_SR1MUX     = 2'b00;
    o_DRMUX      = 2'b00;
    o_PCMUX      = 2'b00;
    o_ADDR1MUX   = 1'b0;
    o_ADDR2MUX   = 2'b00;
    o_MARMUX     = 1'b0;
    o_MIO_EN     = 1'b0;
    o_R_W        = 1'b0;
    o_Illegal    = 1'b0;
    // Controls stay quiet for the whole time reset is held, even though the state reads FETCH1.
    if (i_Reset) begin
      case (state)
        S_FETCH1: begin
          o_GatePC  = 1'b1;
          o_LD_MAR  = 1'b1;
          o_LD_PC   = 1'b1;
          state_nxt = S_FETCH2;
        end
        S_FETCH2, S_LD2: begin
          o_MIO_EN  = 1'b1;
          o_LD_MDR  = 1'b1;
          if (!i_R)                 state_nxt = state;
          else if (state == S_LD2)  state_nxt = S_LD3;
          else                      state_nxt = S_FETCH3;
        end
        S_FETCH3: begin
          o_GateMDR = 1'b1;
          o_LD_IR   = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          case (i_IR[15:12])
            4'b0001: state_nxt = S_ADD;
            4'b0101: state_nxt = S_AND;
            4'b1001: state_nxt = S_NOT;
            4'b0010: state_nxt = S_LD1;
            4'b0011: state_nxt = S_ST1;
            4'b0000: state_nxt = S_BR;
            4'b1110: state_nxt = S_LEA;
            4'b1100: state_nxt = S_JMP;
            default: begin
              state_nxt = S_FETCH1;
              o_Illegal = 1'b1;
            end
          endcase
        end
        S_ADD, S_AND, S_NOT: begin
          o_GateALU = 1'b1;
          o_LD_REG  = 1'b1;
          o_LD_CC   = 1'b1;
          o_SR1MUX  = 2'b01;
          o_ALUK    = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
        end
        S_LEA: begin
          o_ADDR2MUX   = 2'b10;
          o_MARMUX     = 1'b1;
          o_GateMARMUX = 1'b1;
          o_LD_REG     = 1'b1;
        end
        S_LD1, S_ST1: begin
          o_ADDR2MUX   = 2'b10;
          o_MARMUX     = 1'b1;
          o_GateMARMUX = 1'b1;
          o_LD_MAR     = 1'b1;
          state_nxt    = (state == S_LD1) ? S_LD2 : S_ST2;
        end
        S_LD3: begin
          o_GateMDR = 1'b1;
          o_LD_REG  = 1'b1;
          o_LD_CC   = 1'b1;
        end
        // PASSA routes the store source register through the ALU onto the bus.
        S_ST2: begin
          o_ALUK    = 2'b11;
          o_GateALU = 1'b1;
          o_LD_MDR  = 1'b1;
          state_nxt = S_ST3;
        end
        S_ST3: begin
          o_MIO_EN  = 1'b1;
          o_R_W     = 1'b1;
          state_nxt = i_R ? S_FETCH1 : S_ST3;
        end
        S_BR: begin
          state_nxt = br_taken ? S_BR_TAKE : S_FETCH1;
        end
        S_BR_TAKE: begin
          o_PCMUX    = 2'b10;
          o_ADDR2MUX = 2'b10;
          o_LD_PC    = 1'b1;
        end
        S_JMP: begin
          o_SR1MUX   = 2'b01;
          o_ADDR1MUX = 1'b1;
          o_PCMUX    = 2'b10;
          o_LD_PC    = 1'b1;
        end
        default: state_nxt = S_FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class, memory waits, illegal opcodes and reset.
// Control outputs are packed into one vector and compared against hand-written per-state constants.
module tb_control_unit;

  logic        clk, rst_n;
  logic [15:0] ir;
  logic        n, z, p, r;
  logic        ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, ld_pc;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0]  aluk, sr1mux, drmux, pcmux, addr2mux;
  logic        addr1mux, marmux, mio_en, r_w, illegal;
  logic [5:0]  state;
  logic [24:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  control_unit dut (
    .i_CLK(clk), .i_Reset(rst_n), .i_IR(ir),
    .i_N(n), .i_Z(z), .i_P(p), .i_R(r),
    .o_LD_MAR(ld_mar), .o_LD_MDR(ld_mdr), .o_LD_IR(ld_ir),
    .o_LD_REG(ld_reg), .o_LD_CC(ld_cc), .o_LD_PC(ld_pc),
    .o_GatePC(gate_pc), .o_GateMDR(gate_mdr), .o_GateALU(gate_alu),
    .o_GateMARMUX(gate_marmux), .o_ALUK(aluk), .o_SR1MUX(sr1mux),
    .o_DRMUX(drmux), .o_PCMUX(pcmux), .o_ADDR1MUX(addr1mux),
    .o_ADDR2MUX(addr2mux), .o_MARMUX(marmux), .o_MIO_EN(mio_en),
    .o_R_W(r_w), .o_Illegal(illegal), .o_State(state)
  );

  assign ctl = {ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, ld_pc,
                gate_pc, gate_mdr, gate_alu, gate_marmux,
                aluk, sr1mux, drmux, pcmux, addr1mux, addr2mux,
                marmux, mio_en, r_w, illegal};

  // Field order: LD{MAR,MDR,IR,REG,CC,PC} Gate{PC,MDR,ALU,MARMUX} ALUK SR1 DR PCMUX A1 A2 MARMUX MIO RW ILL
  localparam logic [24:0] C_ZERO = 25'd0;
  localparam logic [24:0] C_F1   = {6'b100001, 4'b1000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_MRD  = {6'b010000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [24:0] C_F3   = {6'b001000, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_ILL  = {6'b000000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [24:0] C_ADD  = {6'b000110, 4'b0010, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_AND  = {6'b000110, 4'b0010, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_NOT  = {6'b000110, 4'b0010, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_LEA  = {6'b000100, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_EA   = {6'b100000, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_LD3  = {6'b000110, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_ST2  = {6'b010000, 4'b0010, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_ST3  = {6'b000000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [24:0] C_BRT  = {6'b000001, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] C_JMP  = {6'b000001, 4'b0000, 2'b00, 2'b01, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle (just after a falling edge), then advance one clock.
  task automatic step(input logic [5:0] st, input logic [24:0] c, input string tag);
    #1;
    chk({tag, "_state"}, {26'd0, state}, {26'd0, st});
    chk({tag, "_ctl"}, {7'd0, ctl}, {7'd0, c});
    @(negedge clk);
  endtask

  task automatic fetch_decode(input logic [15:0] instr, input logic [24:0] dec_ctl, input string tag);
    ir = instr;
    r  = 1'b1;
    step(6'd18, C_F1,  {tag, "_f1"});
    step(6'd33, C_MRD, {tag, "_f2"});
    step(6'd35, C_F3,  {tag, "_f3"});
    step(6'd32, dec_ctl, {tag, "_dec"});
  endtask

  initial begin
    rst_n = 1'b1;
    ir = 16'h1042;
    {n, z, p} = 3'b000;
    r = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(6'd18, C_ZERO, "reset_hold");
    rst_n = 1'b1;

    fetch_decode(16'h1042, C_ZERO, "add");
    step(6'd1, C_ADD, "add_ex");

    fetch_decode(16'h5042, C_ZERO, "and");
    step(6'd5, C_AND, "and_ex");

    fetch_decode(16'h967F, C_ZERO, "not");
    step(6'd9, C_NOT, "not_ex");

    fetch_decode(16'h2005, C_ZERO, "ld");
    step(6'd2, C_EA, "ld_ea");
    r = 1'b0;
    step(6'd25, C_MRD, "ld_wait0");
    step(6'd25, C_MRD, "ld_wait1");
    r = 1'b1;
    step(6'd25, C_MRD, "ld_rdy");
    step(6'd27, C_LD3, "ld_wb");

    fetch_decode(16'h3205, C_ZERO, "st");
    step(6'd3, C_EA, "st_ea");
    step(6'd23, C_ST2, "st_mdr");
    r = 1'b0;
    for (int i = 0; i < 3; i++) step(6'd16, C_ST3, "st_wait");
    r = 1'b1;
    step(6'd16, C_ST3, "st_rdy");

    fetch_decode(16'hE1FF, C_ZERO, "lea");
    step(6'd14, C_LEA, "lea_ex");

    fetch_decode(16'hC080, C_ZERO, "jmp");
    step(6'd12, C_JMP, "jmp_ex");

    {n, z, p} = 3'b010;
    fetch_decode(16'h0403, C_ZERO, "brz_t");
    step(6'd0, C_ZERO, "brz_t_br");
    step(6'd22, C_BRT, "brz_t_take");

    {n, z, p} = 3'b101;
    fetch_decode(16'h0403, C_ZERO, "brz_n");
    step(6'd0, C_ZERO, "brz_n_br");

    {n, z, p} = 3'b111;
    fetch_decode(16'h0003, C_ZERO, "br_none");
    step(6'd0, C_ZERO, "br_none_br");

    {n, z, p} = 3'b001;
    fetch_decode(16'h0203, C_ZERO, "brp");
    step(6'd0, C_ZERO, "brp_br");
    step(6'd22, C_BRT, "brp_take");

    fetch_decode(16'hF025, C_ILL, "trap");
    fetch_decode(16'hD000, C_ILL, "rsvd");

    fetch_decode(16'h3205, C_ZERO, "st_rst");
    step(6'd3, C_EA, "st_rst_ea");
    step(6'd23, C_ST2, "st_rst_mdr");
    r = 1'b0;
    step(6'd16, C_ST3, "st_rst_wait");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {26'd0, state}, 32'd18);
    chk("async_rst_ctl", {7'd0, ctl}, {7'd0, C_ZERO});
    chk("async_rst_rw", {31'd0, r_w}, 32'd0);
    @(negedge clk);
    step(6'd18, C_ZERO, "rst_held");
    rst_n = 1'b1;
    r = 1'b1;
    fetch_decode(16'h1042, C_ZERO, "after_rst");
    step(6'd1, C_ADD, "after_rst_ex");
    step(6'd18, C_F1, "after_rst_f1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout state=%0d", state);
    $fatal(1, "bench timeout");
  end

endmodule
